// File: rtl/scale_cache_loader_mc_pkg.sv
// Shared types and default sizes for the multi-bank scale-cache loader.
package scale_cache_loader_mc_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_WORD_SIZE  = 8;
  localparam int DEF_COL_WIDTH  = 9;
  localparam int DEF_ROW_WIDTH  = 9;
  localparam int DEF_NUM_BANKS  = 2;

  // Bank index width; a single bank still needs a 1-bit index.
  function automatic int bank_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_BANK_W = bank_width(DEF_NUM_BANKS);

  // WAIT_BANK: target bank still holds an unreleased frame.
  // FILL: words are being written into the target bank.
  typedef enum logic {
    WAIT_BANK = 1'b0,
    FILL      = 1'b1
  } state_t;

  // Cache write record at the default geometry.
  typedef struct packed {
    logic                      we;
    logic [DEF_WORD_SIZE-1:0]  wdata;
    logic [DEF_COL_WIDTH-1:0]  waddr_x;
    logic [DEF_ROW_WIDTH-1:0]  waddr_y;
    logic [DEF_BANK_W-1:0]     wbank;
  } write_t;

endpackage

// File: rtl/scale_cache_loader_mc_beat_unpacker.sv
// Holds one packed beat and presents its words one per cycle, lowest first.
//
// Handshake: a beat transfers on a rising edge where data_ready && data_wanted.
// data_wanted is derived only from registered state plus flush/enable, never
// from data_ready, so the producer may wait for it before asserting valid.
module scale_cache_loader_mc_beat_unpacker
  import scale_cache_loader_mc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WORD_SIZE  = DEF_WORD_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_ready,
  input  logic                  enable,
  input  logic                  flush,
  output logic                  data_wanted,
  output logic                  word_valid,
  output logic [WORD_SIZE-1:0]  word
);

  localparam int WPB   = DATA_WIDTH / WORD_SIZE;
  localparam int REM_W = $clog2(WPB + 1);

  logic [DATA_WIDTH-1:0] hold;
  logic [REM_W-1:0]      rem;
  logic                  take;

  // Accept a new beat when empty, or when the last buffered word leaves this
  // cycle and does not close the frame (keeps one word per cycle sustained).
  always_comb begin
    word_valid  = enable && (rem != '0);
    data_wanted = enable && ((rem == '0) || ((rem == REM_W'(1)) && !flush));
    take        = data_ready && data_wanted;
    word        = word_valid ? hold[WORD_SIZE-1:0] : '0;
  end

  // Load on transfer, shift on each written word, drop leftovers at frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
      rem  <= '0;
    end else if (take) begin
      hold <= data;
      rem  <= REM_W'(WPB);
    end else if (word_valid) begin
      if (flush) begin
        hold <= '0;
        rem  <= '0;
      end else begin
        hold <= hold >> WORD_SIZE;
        rem  <= rem - REM_W'(1);
      end
    end
  end

endmodule

// File: rtl/scale_cache_loader_mc.sv
// Writes unpacked pixel words in raster order into a ring of cache banks.
// A bank stays full until the consumer releases it; the loader stalls on a
// full target bank and resumes the cycle after its release.
module scale_cache_loader_mc
  import scale_cache_loader_mc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int COL_WIDTH  = DEF_COL_WIDTH,
  parameter int ROW_WIDTH  = DEF_ROW_WIDTH,
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  localparam int BANK_W    = bank_width(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_ready,
  output logic                  data_wanted,
  input  logic [COL_WIDTH-1:0]  cfg_last_x,
  input  logic [ROW_WIDTH-1:0]  cfg_last_y,
  input  logic [NUM_BANKS-1:0]  bank_release,
  output logic                  we,
  output logic [WORD_SIZE-1:0]  wdata,
  output logic [COL_WIDTH-1:0]  waddr_x,
  output logic [ROW_WIDTH-1:0]  waddr_y,
  output logic [BANK_W-1:0]     wbank,
  output logic                  frame_done,
  output logic [NUM_BANKS-1:0]  bank_full
);

  state_t                 state;
  state_t                 state_nxt;
  logic [COL_WIDTH-1:0]   x;
  logic [ROW_WIDTH-1:0]   y;
  logic [COL_WIDTH-1:0]   last_x;
  logic [ROW_WIDTH-1:0]   last_y;
  logic [BANK_W-1:0]      bank;
  logic [BANK_W-1:0]      bank_inc;
  logic [NUM_BANKS-1:0]   full;
  logic [NUM_BANKS-1:0]   full_nxt;
  logic                   word_valid;
  logic [WORD_SIZE-1:0]   word;
  logic                   frame_end;
  logic                   load_cfg;

  scale_cache_loader_mc_beat_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_SIZE  (WORD_SIZE)
  ) u_unpack (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .data_ready  (data_ready),
    .enable      (state == FILL),
    .flush       (frame_end),
    .data_wanted (data_wanted),
    .word_valid  (word_valid),
    .word        (word)
  );

  // Write decode, bank ring step and bank_full update (frame set beats release).
  always_comb begin
    frame_end = word_valid && (x == last_x) && (y == last_y);
    bank_inc  = (bank == BANK_W'(NUM_BANKS - 1)) ? '0 : bank + BANK_W'(1);
    full_nxt  = full & ~bank_release;
    if (frame_end) begin
      full_nxt = full_nxt | (NUM_BANKS'(1) << bank);
    end
  end

  // Next state; frame geometry is captured whenever a new frame begins filling.
  always_comb begin
    state_nxt = state;
    load_cfg  = 1'b0;
    case (state)
      WAIT_BANK: begin
        if (!full_nxt[bank]) begin
          state_nxt = FILL;
          load_cfg  = 1'b1;
        end
      end
      FILL: begin
        if (frame_end) begin
          if (full_nxt[bank_inc]) begin
            state_nxt = WAIT_BANK;
          end else begin
            load_cfg = 1'b1;
          end
        end
      end
      default: state_nxt = WAIT_BANK;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_BANK;
    end else begin
      state <= state_nxt;
    end
  end

  // Raster address counters and bank pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      x    <= '0;
      y    <= '0;
      bank <= '0;
    end else if (word_valid) begin
      if (frame_end) begin
        x    <= '0;
        y    <= '0;
        bank <= bank_inc;
      end else if (x == last_x) begin
        x <= '0;
        y <= y + ROW_WIDTH'(1);
      end else begin
        x <= x + COL_WIDTH'(1);
      end
    end
  end

  // Frame geometry held constant for the whole frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_x <= '0;
      last_y <= '0;
    end else if (load_cfg) begin
      last_x <= cfg_last_x;
      last_y <= cfg_last_y;
    end
  end

  // Per-bank full flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= '0;
    end else begin
      full <= full_nxt;
    end
  end

  assign we         = word_valid;
  assign wdata      = word;
  assign waddr_x    = x;
  assign waddr_y    = y;
  assign wbank      = bank;
  assign frame_done = frame_end;
  assign bank_full  = full;

endmodule
